mul_issue_seq: RTL and testbench

- Sequencer placed directly upstream and downstream of the RV32M multiplier.
- Accepts decoded M-extension ops from execute over a valid/ready handshake.
- Registers the operands and the multiplication code into the multiplier, waits a fixed settle time, then captures the multiplier output.
- Presents the result to writeback over a second valid/ready handshake, with the destination tag attached.

---
 rtl/mul_issue_seq.sv | 154 +++++++++++++++
 tb/tb_mul_issue_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_seq.sv
// Issue/collect sequencer wrapped around the RV32M multiplier: registers operands and
// mulCode, waits SETTLE cycles for the combinational multiplier, then hands the result to writeback.
`ifndef MULC
`define MULC    2'b00
`endif
`ifndef MULHC
`define MULHC   2'b01
`endif
`ifndef MULHSUC
`define MULHSUC 2'b10
`endif
`ifndef MULHUC
`define MULHUC  2'b11
`endif

module mul_issue_seq #(
    parameter int dataW  = 32,
    parameter int SETTLE = 1,
    parameter int tagW   = 5
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [dataW-1:0] in_rs1,
    input  logic [dataW-1:0] in_rs2,
    input  logic [tagW-1:0]  in_rd,
    output logic [dataW-1:0] mul_M,
    output logic [dataW-1:0] mul_Q,
    output logic [dataW-1:0] mul_UM,
    output logic [dataW-1:0] mul_UQ,
    output logic [1:0]       mul_code,
    input  logic [dataW-1:0] mul_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [dataW-1:0] out_data,
    output logic [tagW-1:0]  out_rd,
    output logic             out_wen,
    output logic             out_illegal
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SETTLE_WAIT = 2'd1;
    localparam logic [1:0] HOLD        = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [dataW-1:0] m_q, m_d, q_q, q_d, data_q, data_d;
    logic [1:0]       code_q, code_d;
    logic [tagW-1:0]  rd_q, rd_d;
    logic             valid_q, valid_d, wen_q, wen_d, ill_q, ill_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        code_d  = code_q;
        rd_d    = rd_q;
        data_d  = data_q;
        valid_d = valid_q;
        wen_d   = wen_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d = in_rd;
                    if (in_funct3[2]) begin
                        // Divide/remainder landed here: report it without touching the multiplier.
                        data_d  = '0;
                        ill_d   = 1'b1;
                        wen_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        m_d = in_rs1;
                        q_d = in_rs2;
                        case (in_funct3[1:0])
                            2'b00:   code_d = `MULC;
                            2'b01:   code_d = `MULHC;
                            2'b10:   code_d = `MULHSUC;
                            default: code_d = `MULHUC;
                        endcase
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE_WAIT;
                    end
                end
            end
            SETTLE_WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d  = mul_out;
                    valid_d = 1'b1;
                    ill_d   = 1'b0;
                    wen_d   = (rd_q != '0);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    wen_d   = 1'b0;
                    ill_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            code_q  <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            code_q  <= code_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wen_q   <= wen_d;
            ill_q   <= ill_d;
        end
    end

    // Held low while reset is asserted so execute never sees a ready during reset.
    assign in_ready    = nReset && (state_q == IDLE);
    assign mul_M       = m_q;
    assign mul_UM      = m_q;
    assign mul_Q       = q_q;
    assign mul_UQ      = q_q;
    assign mul_code    = code_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_rd      = rd_q;
    assign out_wen     = wen_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_mul_issue_seq.sv
// Directed bench for mul_issue_seq: SETTLE=1 and SETTLE=3 instances, each fed by a
// behavioural RV32M multiplier model.
module tb_mul_issue_seq;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mmodel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] c);
        logic [63:0] sa, sb, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (c)
            2'd0:    begin p = sa * sb; return p[31:0]; end
            2'd1:    begin p = sa * sb; return p[63:32]; end
            2'd2:    begin p = sa * ub; return p[63:32]; end
            default: begin p = {32'b0, a} * ub; return p[63:32]; end
        endcase
    endfunction

    // SETTLE=1 instance
    logic        in_valid, in_ready, out_ready, out_valid, out_wen, out_illegal;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1, in_rs2, mul_M, mul_Q, mul_UM, mul_UQ, mul_out, out_data;
    logic [4:0]  in_rd, out_rd;
    logic [1:0]  mul_code;

    assign mul_out = mmodel(mul_UM, mul_UQ, mul_code);

    mul_issue_seq #(.dataW(32), .SETTLE(1), .tagW(5)) dut (
        .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .mul_M(mul_M), .mul_Q(mul_Q), .mul_UM(mul_UM), .mul_UQ(mul_UQ),
        .mul_code(mul_code), .mul_out(mul_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_wen(out_wen), .out_illegal(out_illegal)
    );

    // SETTLE=3 instance
    logic        in_valid3, in_ready3, out_ready3, out_valid3, out_wen3, out_illegal3;
    logic [2:0]  in_funct3_3;
    logic [31:0] in_rs1_3, in_rs2_3, mul_M3, mul_Q3, mul_UM3, mul_UQ3, mul_out3, out_data3;
    logic [4:0]  in_rd3, out_rd3;
    logic [1:0]  mul_code3;

    assign mul_out3 = mmodel(mul_M3, mul_Q3, mul_code3);

    mul_issue_seq #(.dataW(32), .SETTLE(3), .tagW(5)) dut3 (
        .clk(clk), .nReset(nReset), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_funct3(in_funct3_3), .in_rs1(in_rs1_3), .in_rs2(in_rs2_3), .in_rd(in_rd3),
        .mul_M(mul_M3), .mul_Q(mul_Q3), .mul_UM(mul_UM3), .mul_UQ(mul_UQ3),
        .mul_code(mul_code3), .mul_out(mul_out3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .out_rd(out_rd3),
        .out_wen(out_wen3), .out_illegal(out_illegal3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op to the SETTLE=1 instance; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_vld_clr"}, out_valid, 0);
        chk({tag, "_wen_clr"}, out_wen, 0);
        chk({tag, "_ill_clr"}, out_illegal, 0);
        chk({tag, "_rdy"}, in_ready, 1);
    endtask

    initial begin
        nReset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0;
        in_funct3_3 = '0; in_rs1_3 = '0; in_rs2_3 = '0; in_rd3 = '0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_wen", out_wen, 0);
        chk("rst_out_ill", out_illegal, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_mul_M", mul_M, 0);
        chk("rst_mul_Q", mul_Q, 0);
        chk("rst_mul_code", mul_code, 0);
        step(); step();
        nReset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // MUL 7 * -3, rd=5
        issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5);
        chk("mul_n_valid", out_valid, 0);
        chk("mul_n_ready", in_ready, 0);
        chk("mul_M", mul_M, 32'd7);
        chk("mul_UQ", mul_UQ, 32'hFFFFFFFD);
        chk("mul_code", mul_code, 2'd0);
        step();
        chk("mul_valid", out_valid, 1);
        chk("mul_data", out_data, 32'hFFFFFFEB);
        chk("mul_rd", out_rd, 5);
        chk("mul_wen", out_wen, 1);
        chk("mul_ill", out_illegal, 0);
        chk("mul_hold_ready", in_ready, 0);
        drain("mul");
        chk("mul_data_kept", out_data, 32'hFFFFFFEB);

        // MULHU with backpressure and ignored in_valid pulses
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
        chk("mulhu_code", mul_code, 2'd3);
        step();
        chk("mulhu_data", out_data, 32'hFFFFFFFE);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd1; in_rs2 = 32'd1; in_rd = 5'd1;
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 32'hFFFFFFFE);
            chk("bp_rd", out_rd, 7);
            chk("bp_ready", in_ready, 0);
            chk("bp_code", mul_code, 2'd3);
            chk("bp_M", mul_M, 32'hFFFFFFFF);
        end
        in_valid = 1'b0;
        drain("mulhu");

        // MULH / MULHSU with the same operands
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
        chk("mulh_code", mul_code, 2'd1);
        step();
        chk("mulh_data", out_data, 32'h00000000);
        chk("mulh_valid", out_valid, 1);
        drain("mulh");
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
        chk("mulhsu_code", mul_code, 2'd2);
        step();
        chk("mulhsu_data", out_data, 32'hFFFFFFFF);
        drain("mulhsu");

        // Illegal funct3: result one edge after acceptance, multiplier inputs untouched
        issue(3'b100, 32'h1234, 32'h5678, 5'd9);
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", out_illegal, 1);
        chk("ill_data", out_data, 0);
        chk("ill_wen", out_wen, 0);
        chk("ill_rd", out_rd, 9);
        chk("ill_M_kept", mul_M, 32'hFFFFFFFF);
        chk("ill_Q_kept", mul_Q, 32'hFFFFFFFF);
        chk("ill_code_kept", mul_code, 2'd2);
        drain("ill");

        // Write to x0
        issue(3'b000, 32'd2, 32'd3, 5'd0);
        step();
        chk("x0_valid", out_valid, 1);
        chk("x0_wen", out_wen, 0);
        chk("x0_data", out_data, 32'd6);
        drain("x0");

        // Reset during SETTLE_WAIT
        issue(3'b000, 32'd5, 32'd5, 5'd3);
        nReset = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 0);
        chk("mrst_M", mul_M, 0);
        step(); step();
        nReset = 1'b1;
        #1;
        chk("mrst_rel_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_no_stale", out_valid, 0);
        end

        // SETTLE=3: latency and back-to-back spacing with out_ready tied high
        out_ready3 = 1'b1;
        in_valid3 = 1'b1; in_funct3_3 = 3'b000; in_rs1_3 = 32'd4; in_rs2_3 = 32'd5; in_rd3 = 5'd1;
        chk("s3_idle_ready", in_ready3, 1);
        step();                                   // edge N: op1 accepted
        in_rs1_3 = 32'd6; in_rs2_3 = 32'd7; in_rd3 = 5'd2;
        chk("s3_n_ready", in_ready3, 0);
        step(); chk("s3_n1_valid", out_valid3, 0);
        step(); chk("s3_n2_valid", out_valid3, 0);
        step(); chk("s3_n3_valid", out_valid3, 1);
        chk("s3_n3_data", out_data3, 32'd20);
        chk("s3_n3_rd", out_rd3, 1);
        step(); chk("s3_n4_valid", out_valid3, 0);
        chk("s3_n4_ready", in_ready3, 1);
        chk("s3_n4_M", mul_M3, 32'd4);
        step();                                   // edge N+5: op2 accepted
        in_valid3 = 1'b0;
        chk("s3_n5_ready", in_ready3, 0);
        chk("s3_n5_M", mul_M3, 32'd6);
        step(); step();
        chk("s3_n7_valid", out_valid3, 0);
        step();
        chk("s3_n8_valid", out_valid3, 1);
        chk("s3_n8_data", out_data3, 32'd42);
        chk("s3_n8_rd", out_rd3, 2);
        step();
        chk("s3_n9_ready", in_ready3, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
